// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: shared op encodings, multiply latency, register width and drain FSM states
package mul_sched_pkg;
  localparam int MUL_LAT = 8;
  localparam int REG_W = 5;
  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;
  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;
endpackage

// File: rtl/mul_sched_if.sv
// mul_sched_if: issue, hazard, writeback and drain signals between decode/issue (master) and the multiply scheduler (slave)
interface mul_sched_if import mul_sched_pkg::*; #(parameter int RW = REG_W);
  logic          issue_valid;
  logic [RW-1:0] issue_rd;
  logic [1:0]    issue_op;
  logic          issue_ready;
  logic [1:0]    mul_op;
  logic [RW-1:0] rs1;
  logic [RW-1:0] rs2;
  logic          hazard;
  logic          fwd1;
  logic          fwd2;
  logic          wb_valid;
  logic [RW-1:0] wb_rd;
  logic          flush;
  logic          drain_req;
  logic          drain_ack;
  logic          busy;
  modport master (
    output issue_valid, issue_rd, issue_op, rs1, rs2, flush, drain_req,
    input  issue_ready, mul_op, hazard, fwd1, fwd2, wb_valid, wb_rd, drain_ack, busy
  );
  modport slave (
    input  issue_valid, issue_rd, issue_op, rs1, rs2, flush, drain_req,
    output issue_ready, mul_op, hazard, fwd1, fwd2, wb_valid, wb_rd, drain_ack, busy
  );
endinterface

// File: rtl/mul_slot_pipe.sv
// mul_slot_pipe: LAT-deep {v, rd, op} shift register with sync clear; stage k holds the op issued k+1 cycles ago (ports: clk, rst, clr, ld_v/ld_rd/ld_op in, all stages out)
module mul_slot_pipe import mul_sched_pkg::*; #(
  parameter int LAT = MUL_LAT,
  parameter int RW  = REG_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   ld_v,
  input  logic [RW-1:0]          ld_rd,
  input  logic [1:0]             ld_op,
  output logic [LAT-1:0]         v,
  output logic [LAT-1:0][RW-1:0] rd,
  output logic [LAT-1:0][1:0]    op
);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      v  <= '0;
      rd <= '0;
      op <= '0;
    end else begin
      v  <= {v[LAT-2:0], ld_v};
      rd <= {rd[LAT-2:0], ld_rd};
      op <= {op[LAT-2:0], ld_op};
    end
  end
endmodule

// File: rtl/mul_sched.sv
// mul_sched: multiply issue/completion scheduler (ports: clk, rst, bus = issue/hazard/writeback/drain slave modport)
module mul_sched import mul_sched_pkg::*; #(
  parameter int LAT = MUL_LAT,
  parameter int RW  = REG_W
) (
  input logic        clk,
  input logic        rst,
  mul_sched_if.slave bus
);
  logic [1:0]             state;
  logic                   accept;
  logic [LAT-1:0]         v;
  logic [LAT-1:0][RW-1:0] rd;
  logic [LAT-1:0][1:0]    op;
  logic [LAT-1:0]         m1;
  logic [LAT-1:0]         m2;
  logic                   h1;
  logic                   h2;
  assign bus.issue_ready = !rst && !bus.flush && state == RUN;
  assign accept = bus.issue_valid && bus.issue_ready;
  assign bus.mul_op = accept ? bus.issue_op : MUL;
  mul_slot_pipe #(.LAT(LAT), .RW(RW)) u_pipe (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.flush),
    .ld_v  (accept),
    .ld_rd (accept ? bus.issue_rd : '0),
    .ld_op (bus.mul_op),
    .v     (v),
    .rd    (rd),
    .op    (op)
  );
  // rs==0 never matches, so rd==0 slots are invisible to hazard/forwarding
  for (genvar i = 0; i < LAT; i++) begin : g_match
    assign m1[i] = v[i] && bus.rs1 != '0 && rd[i] == bus.rs1;
    assign m2[i] = v[i] && bus.rs2 != '0 && rd[i] == bus.rs2;
  end
  // any younger match hides the completing one, so forwarding needs no younger hit
  assign h1 = |m1[LAT-2:0];
  assign h2 = |m2[LAT-2:0];
  assign bus.hazard = h1 || h2;
  assign bus.fwd1 = m1[LAT-1] && !h1;
  assign bus.fwd2 = m2[LAT-1] && !h2;
  assign bus.busy = |v;
  assign bus.wb_valid = v[LAT-1] && rd[LAT-1] != '0;
  assign bus.wb_rd = bus.wb_valid ? rd[LAT-1] : '0;
  // ack as soon as the pipe is observed empty while issue is blocked
  assign bus.drain_ack = state == ACK || (state == DRAIN && !bus.busy);
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else state <= state == RUN   ? (bus.drain_req ? DRAIN : RUN) :
                  state == DRAIN ? (bus.busy ? DRAIN : ACK) :
                                   (bus.drain_req ? ACK : RUN);
  end
endmodule

// File: tb/tb_mul_sched.sv
// tb_mul_sched: directed and random stimulus checked against an issue-history model of the multiply scheduler
module tb_mul_sched;
  localparam int LAT = 8;
  localparam int NC = 8192;
  logic clk = 0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_kill = -1;
  int mode = 0;
  bit acc_h [NC];
  logic [4:0] rd_h [NC];
  bit e_acc, e_busy, e_wbv, e_ack;
  logic [4:0] e_wbr;
  logic [1:0] d1, d2;
  bit dr;
  mul_sched_if #(.RW(5)) bus ();
  mul_sched dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask
  function automatic bit live(input int t);
    return t >= 0 && t < cyc && t < NC && acc_h[t] && t >= last_kill;
  endfunction
  // 2'b10 = hazard, 2'b01 = forward; youngest live producer decides
  function automatic logic [1:0] dep(input logic [4:0] rs);
    for (int t = cyc - 1; t >= cyc - LAT; t--)
      if (rs != 0 && live(t) && rd_h[t] == rs) return (t == cyc - LAT) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction
  always @(negedge clk) begin
    e_acc = bus.issue_valid && !rst && !bus.flush && mode == 0;
    e_busy = 0;
    for (int t = cyc - LAT; t < cyc; t++) if (live(t)) e_busy = 1;
    e_wbv = live(cyc - LAT) && rd_h[cyc - LAT] != 0;
    e_wbr = e_wbv ? rd_h[cyc - LAT] : 5'd0;
    d1 = dep(bus.rs1);
    d2 = dep(bus.rs2);
    e_ack = mode == 2 || (mode == 1 && !e_busy);
    if (cyc >= 1) begin
      chk("issue_ready", bus.issue_ready, !rst && !bus.flush && mode == 0);
      chk("mul_op", bus.mul_op, e_acc ? bus.issue_op : 2'b00);
      chk("busy", bus.busy, e_busy);
      chk("wb_valid", bus.wb_valid, e_wbv);
      chk("wb_rd", bus.wb_rd, e_wbr);
      chk("hazard", bus.hazard, d1[1] || d2[1]);
      chk("fwd1", bus.fwd1, d1[0]);
      chk("fwd2", bus.fwd2, d2[0]);
      chk("drain_ack", bus.drain_ack, e_ack);
    end
    if (cyc < NC) begin
      acc_h[cyc] = e_acc;
      rd_h[cyc] = bus.issue_rd;
    end
    if (rst || bus.flush) last_kill = cyc;
    if (rst) mode = 0;
    else if (mode == 0) mode = bus.drain_req ? 1 : 0;
    else if (mode == 1) mode = e_busy ? 1 : 2;
    else mode = bus.drain_req ? 2 : 0;
    cyc++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr_in();
    bus.issue_valid = 0;
    bus.issue_rd = 0;
    bus.issue_op = 0;
    bus.rs1 = 0;
    bus.rs2 = 0;
    bus.flush = 0;
    bus.drain_req = 0;
  endtask
  initial begin
    rst = 1;
    clr_in();
    repeat (2) tick();
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_ready", bus.issue_ready, 0);
    chk("rst_ack", bus.drain_ack, 0);
    tick();
    rst = 0;
    for (int i = 0; i < 11; i++) begin
      clr_in();
      bus.issue_valid = i == 0;
      bus.issue_rd = 5;
      bus.issue_op = 2'b01;
      @(negedge clk);
      if (i == 0) chk("single_mul_op", bus.mul_op, 2'b01);
      if (i == 1) chk("single_busy", bus.busy, 1);
      if (i == 7) chk("single_early", bus.wb_valid, 0);
      if (i == 8) chk("single_wb", {bus.wb_valid, bus.wb_rd}, {1'b1, 5'd5});
      if (i == 9) chk("single_late", bus.wb_valid, 0);
      tick();
    end
    for (int i = 0; i < 13; i++) begin
      clr_in();
      bus.issue_valid = i < 4;
      bus.issue_rd = (i == 3) ? 5'd0 : 5'(i + 1);
      bus.issue_op = 2'(i);
      @(negedge clk);
      if (i >= 8 && i <= 10) chk("b2b_wb", {bus.wb_valid, bus.wb_rd}, {1'b1, 5'(i - 7)});
      if (i == 11) chk("b2b_rd0", {bus.wb_valid, bus.busy}, 2'b01);
      tick();
    end
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 10; i++) begin
        clr_in();
        bus.issue_valid = i == 0;
        bus.issue_rd = 7;
        bus.rs1 = (p == 0) ? 5'd7 : 5'd0;
        bus.rs2 = (p == 1) ? 5'd7 : 5'd0;
        @(negedge clk);
        if (i == 1) chk("hz_early", bus.hazard, p != 2);
        if (i == 8) chk("hz_fwd", {bus.hazard, bus.fwd1, bus.fwd2}, {1'b0, p == 0, p == 1});
        if (i == 9) chk("hz_done", {bus.hazard, bus.fwd1, bus.fwd2}, 3'b000);
        tick();
      end
    for (int i = 0; i < 15; i++) begin
      clr_in();
      bus.issue_valid = i == 0 || i == 5;
      bus.issue_rd = 4;
      bus.rs1 = 4;
      @(negedge clk);
      if (i == 8) chk("young_hz", {bus.hazard, bus.fwd1}, 2'b10);
      if (i == 13) chk("young_fwd", {bus.hazard, bus.fwd1}, 2'b01);
      tick();
    end
    for (int i = 0; i < 9; i++) begin
      clr_in();
      bus.issue_valid = i <= 4;
      bus.issue_rd = 5'(i + 1);
      bus.flush = i == 4;
      @(negedge clk);
      if (i == 4) chk("flush_drop", {bus.issue_ready, bus.mul_op}, 3'b000);
      if (i == 5) chk("flush_busy", bus.busy, 0);
      if (i >= 5) chk("flush_nowb", bus.wb_valid, 0);
      tick();
    end
    for (int i = 0; i < 15; i++) begin
      clr_in();
      bus.issue_valid = i <= 1 || i == 3;
      bus.issue_rd = 5'(9 + i);
      bus.drain_req = i == 2;
      @(negedge clk);
      if (i == 3) chk("drain_block", bus.issue_ready, 0);
      if (i == 9) chk("drain_wait", {bus.busy, bus.drain_ack}, 2'b10);
      if (i == 10 || i == 11) chk("drain_ack", bus.drain_ack, 1);
      if (i == 12) chk("drain_exit", {bus.drain_ack, bus.issue_ready}, 2'b01);
      tick();
    end
    for (int i = 0; i < 13; i++) begin
      clr_in();
      bus.issue_valid = i < 4;
      bus.issue_rd = 5'(i + 1);
      rst = i == 4;
      @(negedge clk);
      if (i == 4) chk("rst_mid_ready", bus.issue_ready, 0);
      if (i == 5) chk("rst_mid_busy", bus.busy, 0);
      if (i >= 5) chk("rst_mid_nowb", bus.wb_valid, 0);
      tick();
    end
    rst = 0;
    dr = 0;
    for (int i = 0; i < 2000; i++) begin
      rst = $urandom_range(99) == 0;
      if ($urandom_range(29) == 0) dr = !dr;
      bus.drain_req = dr;
      bus.flush = $urandom_range(39) == 0;
      bus.issue_valid = $urandom_range(1) == 1;
      bus.issue_rd = 5'($urandom_range(7));
      bus.issue_op = 2'($urandom_range(3));
      bus.rs1 = 5'($urandom_range(7));
      bus.rs2 = 5'($urandom_range(7));
      tick();
    end
    rst = 0;
    clr_in();
    repeat (12) tick();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_sched.md
Name: mul_sched

Overview:
- Issue/completion scheduler for the 8-cycle pipelined multiply unit. Sits between decode/issue and the multiply unit plus register-file writeback.
- Tracks every in-flight multiply: valid, destination register and op type. Drives the multiply unit's op select.
- Produces the writeback strobe and rd exactly when the result appears.
- Flags RAW hazards and forwarding opportunities for younger instructions.
- Runs a drain handshake so fences and CSR ops wait until all multiplies retire.

Parameters:
- LAT, 8: multiply latency in cycles. Must equal the multiply unit's latency.
- RW, 5: register index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_valid  in  1  multiply issued this cycle; operands present at the multiply unit this cycle
- issue_rd  in  RW  destination register
- issue_op  in  2  00 mul, 01 mulh, 10 mulhsu, 11 mulhu
- issue_ready  out  1  scheduler accepts an issue this cycle
- mul_op  out  2  op select to the multiply unit; equals issue_op when issue_valid && issue_ready, else 00
- rs1  in  RW  younger instruction source register 1
- rs2  in  RW  younger instruction source register 2
- hazard  out  1  a source depends on an in-flight result that is not yet available
- fwd1  out  1  rs1 matches the completing result; take it from the multiply result bus
- fwd2  out  1  rs2 matches the completing result; take it from the multiply result bus
- wb_valid  out  1  multiply result valid at the multiply result bus this cycle
- wb_rd  out  RW  destination register for wb_valid
- flush  in  1  kill all in-flight multiplies (branch mispredict or trap)
- drain_req  in  1  request to quiesce
- drain_ack  out  1  multiply pipeline is empty and issue is blocked
- busy  out  1  any slot valid

Behaviour:
- Tracking structure: a LAT-stage shift register of slots {v, rd, op}. Stage k holds the op issued k+1 cycles ago.
  - Accepted issue at cycle t loads stage 0 at t+1.
  - The slot reaches stage LAT-1 at t+LAT.
  - Stages shift every cycle; the multiply pipeline never stalls.
- Writeback:
  - wb_valid = stage[LAT-1].v and wb_rd = stage[LAT-1].rd, both combinational from registers.
  - Issue at t gives wb_valid at t+LAT, so 8 cycles by default.
  - Back-to-back issues complete back-to-back.
- rd==0:
  - The slot is still tracked, so busy and drain stay correct.
  - wb_valid is suppressed, and the slot is never hazard or forward matched.
- Hazard and forwarding (combinational):
  - For each rsX != 0, match against stages 0..LAT-2: any valid slot with an equal rd raises hazard.
  - A match at stage LAT-1 raises fwdX instead.
  - When several stages match, the youngest match decides. Youngest means the lowest stage index.
  - Example: an older multiply is in stage LAT-1 and a younger one to the same rd is in stage 3. Result: hazard=1, fwdX=0.
  - Same-cycle issue is not checked. Issue logic compares against its own issuing instruction.
- issue_ready = !rst && !flush && state==RUN. An issue with issue_ready=0 is ignored and loads nothing.
- Flush:
  - Clears all slot v bits at the next edge.
  - An issue in the same cycle is dropped.
  - wb_valid in the flush cycle itself is still asserted, because that op is older than the flush.
- Drain FSM, reset state RUN:
  - RUN: when drain_req=1, go to DRAIN.
  - DRAIN: issue_ready=0. When no slot is valid (busy=0), go to ACK.
  - ACK: drain_ack=1. When drain_req=0, go to RUN.
  - A drain_req pulse shorter than the drain is still honoured. ACK holds until drain_req is low.
  - Flush during DRAIN empties the slots, so ACK follows on the next cycle.
- Reset values: all slot v=0 and rd/op=0, state=RUN. Outputs: wb_valid=0, wb_rd=0, hazard=0, fwd1=0, fwd2=0, busy=0, drain_ack=0, mul_op=00, issue_ready=0 while rst is high.
- Reset mid-operation discards in-flight slots. No writeback for them ever follows.
- No arithmetic. Comparisons are RW-bit equality.

Decomposition:
- Shared package holds:
  - Op encodings: MUL=2'b00, MULH=2'b01, MULHSU=2'b10, MULHU=2'b11.
  - The default multiply latency constant (8), used by this block and the multiply unit.
  - The RW width.
  - FSM state encodings: RUN, DRAIN, ACK.
- One natural sub-module: mul_slot_pipe. It is the LAT-deep {v, rd, op} shift register with a synchronous clear, exposing all stages for the match logic.
- Hazard and forward priority logic and the FSM stay in mul_sched.

Test Plan:
- Single issue: rd=5, op=01 at cycle 10 -> mul_op=01 in cycle 10; wb_valid=1 with wb_rd=5 in cycle 18 only; busy high cycles 11..18.
- Back-to-back: rd=1,2,3 at cycles 0,1,2 -> wb_valid cycles 8,9,10 with wb_rd 1,2,3; rd=0 issue in the same stream gives no wb_valid but busy stays high.
- Hazard/forward: issue rd=7 at cycle 0, hold rs1=7 -> hazard=1 cycles 1..7; fwd1=1, hazard=0 in cycle 8; both 0 in cycle 9. Repeat with rs2=7 -> fwd2. rs1=0 -> never flagged.
- Youngest-wins: rd=4 issued at cycles 0 and 5, rs1=4 -> cycle 8 gives hazard=1, fwd1=0; cycle 13 gives fwd1=1.
- Flush: issue at cycles 0..3, flush at cycle 4 with issue_valid=1 -> no wb_valid from cycle 5 onward, busy=0 at cycle 5, the cycle-4 issue is dropped.
- Drain and reset: drain_req pulse at cycle 2 with ops issued at cycles 0,1 -> issue_ready=0 from cycle 3, drain_ack=1 once busy=0 (cycle 10), held until drain_req low. Separately, rst at cycle 4 after issues -> no wb_valid ever, all outputs at reset values.
